// File: rtl/gpio_subsys_pkg.sv
// Shared register map, defaults and byte-strobe helper for the GPIO subsystem.
package gpio_subsys_pkg;

  localparam logic [7:0] GPIO_DOUT_OFS = 8'h00;
  localparam logic [7:0] GPIO_DIR_OFS  = 8'h04;
  localparam logic [7:0] GPIO_DIN_OFS  = 8'h08;
  localparam logic [7:0] GPIO_SET_OFS  = 8'h0C;
  localparam logic [7:0] GPIO_CLR_OFS  = 8'h10;
  localparam logic [7:0] GPIO_TOG_OFS  = 8'h14;
  localparam logic [7:0] GPIO_EDGE_OFS = 8'h18;
  localparam logic [7:0] GPIO_ID_OFS   = 8'h1C;

  localparam logic [31:0] GPIO_ID_DEFAULT = 32'h4750_494F;

  typedef struct packed {
    logic        write;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } gpio_req_t;

  // Bytes of wdata with their strobe set replace the matching bytes of cur.
  function automatic logic [31:0] wstrb_merge(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Parameterised-width two-flop synchronizer, synchronous active-low reset.
module gpio_sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_subsys_top.sv
// GPIO register block behind a valid/ready slave port. Define GPIO_SUBSYS_PADS_EN
// to bring gpio_in/gpio_out/gpio_oe out; otherwise inputs loop back from DOUT & DIR.
module gpio_subsys_top
  import gpio_subsys_pkg::*;
#(
  parameter int          NGPIO    = 32,
  parameter logic [31:0] ID_VALUE = GPIO_ID_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             bus_valid,
  input  logic [23:0]      bus_addr,
  input  logic             bus_write,
  input  logic [31:0]      bus_wdata,
  input  logic [3:0]       bus_wstrb,
  output logic [31:0]      bus_rdata,
  output logic             bus_ready
`ifdef GPIO_SUBSYS_PADS_EN
  ,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_oe
`endif
);

  localparam logic [32:0] ONE33     = 33'd1;
  localparam logic [31:0] LINE_MASK = 32'((ONE33 << NGPIO) - ONE33);

  gpio_req_t   req;
  logic        accept, in_page, wr_en;
  logic [7:0]  ofs;
  logic [31:0] wmask, rd_data;
  logic [31:0] dout, dir, edge_lat, din, din_prev;
  logic [31:0] dout_nxt, dir_nxt, edge_clr, edge_nxt;
  logic [NGPIO-1:0] pad_in, din_n;
  logic        unused_bits;

  assign req = '{write: bus_write, addr: bus_addr, wdata: bus_wdata, wstrb: bus_wstrb};

  // A request is taken only while no completion pulse is out, giving 2-cycle accesses.
  assign accept      = bus_valid & ~bus_ready;
  assign in_page     = (req.addr[23:8] == 16'h0);
  assign ofs         = {req.addr[7:2], 2'b00};
  assign wr_en       = accept & req.write & in_page;
  assign wmask       = wstrb_merge(32'h0, req.wdata, req.wstrb) & LINE_MASK;
  assign unused_bits = ^req.addr[1:0];

`ifdef GPIO_SUBSYS_PADS_EN
  assign pad_in   = gpio_in;
  assign gpio_out = dout[NGPIO-1:0];
  assign gpio_oe  = dir[NGPIO-1:0];
`else
  assign pad_in   = dout[NGPIO-1:0] & dir[NGPIO-1:0];
`endif

  gpio_sync2 #(.WIDTH(NGPIO)) u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (pad_in),
    .q     (din_n)
  );

  assign din = 32'(din_n);

  always_comb begin
    dout_nxt = dout;
    dir_nxt  = dir;
    edge_clr = 32'h0;
    if (wr_en) begin
      case (ofs)
        GPIO_DOUT_OFS: dout_nxt = wstrb_merge(dout, req.wdata, req.wstrb) & LINE_MASK;
        GPIO_DIR_OFS:  dir_nxt  = wstrb_merge(dir, req.wdata, req.wstrb) & LINE_MASK;
        GPIO_SET_OFS:  dout_nxt = dout | wmask;
        GPIO_CLR_OFS:  dout_nxt = dout & ~wmask;
        GPIO_TOG_OFS:  dout_nxt = dout ^ wmask;
        GPIO_EDGE_OFS: edge_clr = wmask;
        default: ;
      endcase
    end
    // Rising edges are ORed in after the clear so a coincident set survives.
    edge_nxt = (edge_lat & ~edge_clr) | (din & ~din_prev);
  end

  always_comb begin
    rd_data = 32'h0;
    if (in_page) begin
      case (ofs)
        GPIO_DOUT_OFS: rd_data = dout;
        GPIO_DIR_OFS:  rd_data = dir;
        GPIO_DIN_OFS:  rd_data = din;
        GPIO_EDGE_OFS: rd_data = edge_lat;
        GPIO_ID_OFS:   rd_data = ID_VALUE;
        default:       rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      dout      <= 32'h0;
      dir       <= 32'h0;
      edge_lat  <= 32'h0;
      din_prev  <= 32'h0;
      bus_ready <= 1'b0;
      bus_rdata <= 32'h0;
    end else begin
      dout      <= dout_nxt;
      dir       <= dir_nxt;
      edge_lat  <= edge_nxt;
      din_prev  <= din;
      bus_ready <= accept;
      bus_rdata <= (accept && !req.write) ? rd_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_gpio_subsys_top.sv
// Randomized bench for gpio_subsys_top against a timestamped register/pad model.
module tb_gpio_subsys_top;

  logic        sys_clk, rst_n, bus_valid, bus_write, bus_ready;
  logic [23:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  gpio_subsys_top dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_write (bus_write),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Model: register values plus a history of pad values and pending edge sets,
  // each stamped with the cycle in which it takes effect.
  typedef struct { int cyc; logic [31:0] val; } ev_t;
  logic [31:0] m_dout, m_dir, m_edge;
  ev_t hist[$];
  ev_t pend[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_dout = 0; m_dir = 0; m_edge = 0;
    hist.delete(); pend.delete();
    hist.push_back('{cyc: -1000, val: 32'h0});
  endfunction

  function automatic void apply_pending(input int t);
    ev_t keep[$];
    foreach (pend[i])
      if (pend[i].cyc < t) m_edge |= pend[i].val;
      else keep.push_back(pend[i]);
    pend = keep;
  endfunction

  // Pad changes reach a read 3 edges after the committing edge.
  function automatic logic [31:0] din_at(input int t);
    logic [31:0] v = 0;
    foreach (hist[i]) if (hist[i].cyc <= t - 3) v = hist[i].val;
    return v;
  endfunction

  function automatic logic [31:0] model_op(input int t, input logic wr, input logic [23:0] a,
                                           input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] bm, m, old_pad, new_pad;
    int word;
    apply_pending(t);
    word = int'(a[7:2]);
    bm = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
    m  = wd & bm;
    if (a[23:8] != 0 || word >= 8) return 32'h0;
    if (!wr) begin
      case (word)
        0: return m_dout;
        1: return m_dir;
        2: return din_at(t);
        6: return m_edge;
        7: return 32'h4750_494F;
        default: return 32'h0;
      endcase
    end
    old_pad = m_dout & m_dir;
    case (word)
      0: m_dout = (m_dout & ~bm) | m;
      1: m_dir  = (m_dir & ~bm) | m;
      3: m_dout = m_dout | m;
      4: m_dout = m_dout & ~m;
      5: m_dout = m_dout ^ m;
      6: m_edge = m_edge & ~m;
      default: ;
    endcase
    new_pad = m_dout & m_dir;
    if (new_pad != old_pad) begin
      hist.push_back('{cyc: t, val: new_pad});
      if ((new_pad & ~old_pad) != 0) pend.push_back('{cyc: t + 3, val: new_pad & ~old_pad});
    end
    return 32'h0;
  endfunction

  task automatic xfer(input logic wr, input logic [23:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd);
    int waited;
    logic [31:0] exp;
    @(negedge sys_clk);
    bus_valid = 1'b1; bus_write = wr; bus_addr = a; bus_wdata = wd; bus_wstrb = ws;
    waited = 0;
    do begin
      @(posedge sys_clk); #1;
      waited++;
    end while (!bus_ready && waited < 8);
    chk("ready_latency", 32'(waited), 32'd1);
    rd = bus_rdata;
    bus_valid = 1'b0;
    exp = model_op(cyc, wr, a, wd, ws);
    chk($sformatf("rdata %s@%h", wr ? "wr" : "rd", a), rd, exp);
    @(posedge sys_clk); #1;
    chk("ready_pulse_width", 32'(bus_ready), 32'd0);
    chk("rdata_idle", bus_rdata, 32'h0);
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] rd;
    xfer(1'b1, a, d, s, rd);
  endtask

  task automatic rd_exp(input string tag, input logic [23:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    xfer(1'b0, a, 32'h0, 4'h0, rd);
    chk(tag, rd, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; bus_valid = 1'b0; bus_write = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_ready", 32'(bus_ready), 32'd0);
    chk("reset_rdata", bus_rdata, 32'h0);
    @(negedge sys_clk) rst_n = 1'b1;

    rd_exp("id", 24'h00001C, 32'h4750_494F);
    rd_exp("dout_rst", 24'h000000, 32'h0);
    rd_exp("dir_rst", 24'h000004, 32'h0);
    rd_exp("edge_rst", 24'h000018, 32'h0);

    wr(24'h000000, 32'hA5A5_1234, 4'b0101);
    rd_exp("dout_wstrb", 24'h000000, 32'h00A5_0034);

    wr(24'h000004, 32'hFFFF_FFFF);
    wr(24'h000000, 32'h0);
    wr(24'h00000C, 32'h0000_00F0);
    wr(24'h000010, 32'h0000_0030);
    wr(24'h000014, 32'h0000_000F);
    rd_exp("dout_sct", 24'h000000, 32'h0000_00CF);
    rd_exp("set_rd0", 24'h00000C, 32'h0);
    rd_exp("clr_rd0", 24'h000010, 32'h0);
    rd_exp("tog_rd0", 24'h000014, 32'h0);

    // Back-to-back read lands before the synchronizer has caught up.
    wr(24'h000000, 32'h0);
    wr(24'h000004, 32'h0000_000F);
    wr(24'h000000, 32'hFFFF_FFFF);
    rd_exp("din_early", 24'h000008, 32'h0);
    rd_exp("din_settled", 24'h000008, 32'h0000_000F);

    wr(24'h000018, 32'hFFFF_FFFF);
    rd_exp("edge_cleared", 24'h000018, 32'h0);
    wr(24'h000000, 32'h0);
    repeat (4) @(posedge sys_clk);
    wr(24'h000000, 32'h1);
    repeat (4) @(posedge sys_clk);
    rd_exp("edge_rise", 24'h000018, 32'h1);
    wr(24'h000018, 32'h1);
    rd_exp("edge_w1c", 24'h000018, 32'h0);

    // Clear committed on the same edge the new rise is latched.
    wr(24'h000000, 32'h0);
    repeat (4) @(posedge sys_clk);
    wr(24'h000000, 32'h1);
    @(posedge sys_clk);
    wr(24'h000018, 32'h1);
    rd_exp("edge_set_wins", 24'h000018, 32'h1);

    wr(24'h000100, 32'h1234_5678);
    wr(24'h000020, 32'hFFFF_FFFF);
    wr(24'h00001C, 32'hFFFF_FFFF);
    rd_exp("unmapped_rd", 24'h000100, 32'h0);
    rd_exp("unmapped_dout", 24'h000000, 32'h1);
    rd_exp("unmapped_dir", 24'h000004, 32'h0000_000F);
    rd_exp("id_ro", 24'h00001C, 32'h4750_494F);

    for (int i = 0; i < 300; i++) begin
      logic [23:0] a;
      a = {16'h0, 3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) a[7:5] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 15) == 0) a[23:8] = 16'($urandom);
      xfer(1'($urandom), a, $urandom, 4'($urandom), rd);
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
    end

    // Reset while a write is pending: no completion and nothing committed.
    @(negedge sys_clk);
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 24'h0;
    bus_wdata = 32'hFFFF_FFFF; bus_wstrb = 4'hF; rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_pending_ready", 32'(bus_ready), 32'd0);
    @(negedge sys_clk);
    bus_valid = 1'b0; rst_n = 1'b1;
    model_reset();
    rd_exp("rst_pending_dout", 24'h000000, 32'h0);
    rd_exp("rst_pending_dir", 24'h000004, 32'h0);
    rd_exp("rst_pending_edge", 24'h000018, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
